// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH = 33;
    localparam int FIFO_DEFAULT_DEPTH = 8;

    // Number of address bits needed to index 'depth' slots (ceil(log2(depth))).
    function automatic int ptr_width(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param; master drives requests, slave is the FIFO.
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH = FIFO_DEFAULT_DEPTH
);
    localparam int CW = ptr_width(DEPTH) + 1;

    logic             WE;
    logic [WIDTH-1:0] IN;
    logic             RE;
    logic [WIDTH-1:0] OUT;
    logic             VALID;
    logic             FULL;
    logic             EMPTY;
    logic             ALMOST_FULL;
    logic             ALMOST_EMPTY;
    logic [CW-1:0]    COUNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output WE, IN, RE,
        input  OUT, VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  WE, IN, RE,
        output OUT, VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH = FIFO_DEFAULT_DEPTH,
    localparam int AW   = ptr_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write.
    // NOTE: the array has no reset; occupancy is tracked by the controller, so stale contents are never observed and the array can map to RAM.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointers, explicit occupancy count, registered flags, standard or FWFT read.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH    = FIFO_DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter bit FWFT     = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    fifo_sync_param_if.slave  bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_sync_param: DEPTH must be a power of two >= 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("fifo_sync_param: WIDTH must be >= 1");
        end
    endgenerate

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, af_q, ae_q;
    logic             ovf_q, udf_q, valid_q;
    logic [WIDTH-1:0] out_q, head_word;
    logic             wr_acc, rd_acc, ram_we;

    // Accept decisions from registered FULL/EMPTY only, and the resulting next occupancy.
    // NOTE: every output of a combinational block is assigned on every path, so no latch can be inferred.
    always_comb begin
        wr_acc  = bus.WE && !full_q;
        rd_acc  = bus.RE && !empty_q;
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end

    // Writes in the reset cycle must not reach the array.
    assign ram_we = wr_acc && !RESET;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (bus.IN),
        .raddr (rd_ptr_q),
        .rdata (head_word)
    );

    // Pointers, count, registered flags, error pulses and the standard-mode read register.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            valid_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                out_q    <= head_word;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            af_q    <= (count_d >= CW'(AF_LEVEL));
            ae_q    <= (count_d <= CW'(AE_LEVEL));
            ovf_q   <= bus.WE && full_q;
            udf_q   <= bus.RE && empty_q;
            valid_q <= rd_acc;
        end
    end

    assign bus.OUT          = FWFT ? (empty_q ? '0 : head_word) : out_q;
    assign bus.VALID        = FWFT ? !empty_q : valid_q;
    assign bus.FULL         = full_q;
    assign bus.EMPTY        = empty_q;
    assign bus.ALMOST_FULL  = af_q;
    assign bus.ALMOST_EMPTY = ae_q;
    assign bus.COUNT        = count_q;
    assign bus.OVERFLOW     = ovf_q;
    assign bus.UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a standard-mode and an FWFT instance share stimulus and a queue-based reference model.
module tb_fifo_sync_param;

    localparam int WIDTH    = 33;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = DEPTH - 2;
    localparam int AE_LEVEL = 1;
    localparam logic [32:0] BASE = 33'h1_0000_0000;

    logic        CLK;
    logic        rst;
    logic        we;
    logic        re;
    logic [32:0] din;
    bit          check_en;

    int n_checks;
    int n_errors;

    fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_std ();
    fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_fw ();

    assign bus_std.WE = we;
    assign bus_std.IN = din;
    assign bus_std.RE = re;
    assign bus_fw.WE  = we;
    assign bus_fw.IN  = din;
    assign bus_fw.RE  = re;

    fifo_sync_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(1'b0)
    ) u_std (
        .CLK   (CLK),
        .RESET (rst),
        .bus   (bus_std)
    );

    fifo_sync_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(1'b1)
    ) u_fw (
        .CLK   (CLK),
        .RESET (rst),
        .bus   (bus_fw)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the stored words as a queue plus the expected pulse/read-register values.
    logic [32:0] mq[$];
    logic [32:0] m_out_std;
    logic        m_valid_std;
    logic        m_ovf;
    logic        m_udf;

    initial begin
        m_out_std   = '0;
        m_valid_std = 1'b0;
        m_ovf       = 1'b0;
        m_udf       = 1'b0;
    end

    always @(posedge CLK) begin
        int sz;
        bit is_full, is_empty;
        sz       = mq.size();
        is_full  = (sz == DEPTH);
        is_empty = (sz == 0);
        if (rst) begin
            mq.delete();
            m_out_std   = '0;
            m_valid_std = 1'b0;
            m_ovf       = 1'b0;
            m_udf       = 1'b0;
        end else begin
            m_ovf = we && is_full;
            m_udf = re && is_empty;
            if (re && !is_empty) begin
                m_out_std   = mq.pop_front();
                m_valid_std = 1'b1;
            end else begin
                m_valid_std = 1'b0;
            end
            if (we && !is_full) begin
                mq.push_back(din);
            end
        end
        #1;
        if (check_en) begin
            sz = mq.size();
            check("std COUNT", 64'(bus_std.COUNT), 64'(sz));
            check("fw COUNT", 64'(bus_fw.COUNT), 64'(sz));
            check("std FULL", 64'(bus_std.FULL), 64'(sz == DEPTH));
            check("fw FULL", 64'(bus_fw.FULL), 64'(sz == DEPTH));
            check("std EMPTY", 64'(bus_std.EMPTY), 64'(sz == 0));
            check("fw EMPTY", 64'(bus_fw.EMPTY), 64'(sz == 0));
            check("std ALMOST_FULL", 64'(bus_std.ALMOST_FULL), 64'(sz >= AF_LEVEL));
            check("fw ALMOST_FULL", 64'(bus_fw.ALMOST_FULL), 64'(sz >= AF_LEVEL));
            check("std ALMOST_EMPTY", 64'(bus_std.ALMOST_EMPTY), 64'(sz <= AE_LEVEL));
            check("fw ALMOST_EMPTY", 64'(bus_fw.ALMOST_EMPTY), 64'(sz <= AE_LEVEL));
            check("std OVERFLOW", 64'(bus_std.OVERFLOW), 64'(m_ovf));
            check("fw OVERFLOW", 64'(bus_fw.OVERFLOW), 64'(m_ovf));
            check("std UNDERFLOW", 64'(bus_std.UNDERFLOW), 64'(m_udf));
            check("fw UNDERFLOW", 64'(bus_fw.UNDERFLOW), 64'(m_udf));
            check("std VALID", 64'(bus_std.VALID), 64'(m_valid_std));
            check("std OUT", 64'(bus_std.OUT), 64'(m_out_std));
            check("fw VALID", 64'(bus_fw.VALID), 64'(sz != 0));
            if (sz != 0) begin
                check("fw OUT", 64'(bus_fw.OUT), 64'(mq[0]));
            end
        end
    end

    // Apply one cycle of inputs (called at a falling edge), return at the next falling edge.
    task automatic step(input logic w, input logic [32:0] d, input logic r, input logic rs);
        we  = w;
        din = d;
        re  = r;
        rst = rs;
        @(negedge CLK);
    endtask

    initial begin
        logic [32:0] exp_word;
        int          phase;
        int          p_we;
        int          p_re;
        n_checks = 0;
        n_errors = 0;
        check_en = 1'b0;
        rst = 1'b1;
        we  = 1'b0;
        re  = 1'b0;
        din = '0;
        @(negedge CLK);
        check_en = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Reset then idle.
        check("reset COUNT", 64'(bus_std.COUNT), 64'd0);
        check("reset EMPTY", 64'(bus_std.EMPTY), 64'd1);
        check("reset ALMOST_EMPTY", 64'(bus_std.ALMOST_EMPTY), 64'd1);
        check("reset ALMOST_FULL", 64'(bus_std.ALMOST_FULL), 64'd0);
        check("reset FULL", 64'(bus_std.FULL), 64'd0);
        check("reset VALID", 64'(bus_std.VALID), 64'd0);
        check("reset OUT", 64'(bus_std.OUT), 64'd0);
        check("reset fw VALID", 64'(bus_fw.VALID), 64'd0);

        // Fill to full; ALMOST_FULL first seen at COUNT=6.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, BASE + 33'(i), 1'b0, 1'b0);
            check("fill COUNT", 64'(bus_std.COUNT), 64'(i + 1));
            if (i == 4) check("fill AF at 5", 64'(bus_std.ALMOST_FULL), 64'd0);
            if (i == 5) check("fill AF at 6", 64'(bus_std.ALMOST_FULL), 64'd1);
        end
        check("fill FULL", 64'(bus_std.FULL), 64'd1);
        step(1'b1, 33'h0_DEAD_BEEF, 1'b0, 1'b0);
        check("9th write OVERFLOW", 64'(bus_std.OVERFLOW), 64'd1);
        check("9th write COUNT", 64'(bus_std.COUNT), 64'd8);
        step(1'b0, '0, 1'b0, 1'b0);
        check("OVERFLOW one cycle", 64'(bus_std.OVERFLOW), 64'd0);

        // Drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            check("fw head before pop", 64'(bus_fw.OUT), 64'(BASE + 33'(i)));
            step(1'b0, '0, 1'b1, 1'b0);
            check("std read OUT", 64'(bus_std.OUT), 64'(BASE + 33'(i)));
            check("std read VALID", 64'(bus_std.VALID), 64'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check("9th read UNDERFLOW", 64'(bus_std.UNDERFLOW), 64'd1);
        check("9th read VALID", 64'(bus_std.VALID), 64'd0);
        check("9th read OUT held", 64'(bus_std.OUT), 64'(BASE + 33'd7));
        check("9th read EMPTY", 64'(bus_std.EMPTY), 64'd1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("UNDERFLOW one cycle", 64'(bus_std.UNDERFLOW), 64'd0);

        // Simultaneous read+write at COUNT=3, pointers wrap.
        for (int j = 0; j < 3; j++) step(1'b1, 33'(100 + j), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 33'(200 + k), 1'b1, 1'b0);
            exp_word = (k < 3) ? 33'(100 + k) : 33'(200 + k - 3);
            check("rw COUNT", 64'(bus_std.COUNT), 64'd3);
            check("rw OUT", 64'(bus_std.OUT), 64'(exp_word));
        end
        for (int j = 0; j < 3; j++) step(1'b0, '0, 1'b1, 1'b0);
        check("rw drained", 64'(bus_std.OUT), 64'(33'd219));

        // FWFT fall-through of a single word.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 33'h0AA, 1'b0, 1'b0);
        check("fwft OUT", 64'(bus_fw.OUT), 64'h0AA);
        check("fwft VALID", 64'(bus_fw.VALID), 64'd1);
        check("std no VALID on write", 64'(bus_std.VALID), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("fwft pop EMPTY", 64'(bus_fw.EMPTY), 64'd1);
        check("fwft pop VALID", 64'(bus_fw.VALID), 64'd0);
        check("std pop OUT", 64'(bus_std.OUT), 64'h0AA);

        // Reset at COUNT=5 with WE high discards everything.
        for (int j = 0; j < 5; j++) step(1'b1, 33'(300 + j), 1'b0, 1'b0);
        check("pre-reset COUNT", 64'(bus_std.COUNT), 64'd5);
        step(1'b1, 33'h1_2345_6789, 1'b0, 1'b1);
        check("mid reset COUNT", 64'(bus_std.COUNT), 64'd0);
        check("mid reset EMPTY", 64'(bus_std.EMPTY), 64'd1);
        check("mid reset fw VALID", 64'(bus_fw.VALID), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post reset UNDERFLOW", 64'(bus_std.UNDERFLOW), 64'd1);
        check("post reset VALID", 64'(bus_std.VALID), 64'd0);

        // Randomised traffic with fill-biased, drain-biased and balanced phases.
        for (int c = 0; c < 3000; c++) begin
            phase = (c / 150) % 3;
            p_we  = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
            p_re  = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
            step(($urandom_range(0, 99) < p_we),
                 {1'($urandom_range(0, 1)), 32'($urandom)},
                 ($urandom_range(0, 99) < p_re),
                 ($urandom_range(0, 299) == 0));
        end

        step(1'b0, '0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
